// File: rtl/plate_sequencer.sv
// Plate command sequencer: arbitrates input channels, gravity ticks and the commit/check/new
// auto-sequence onto a single-outstanding executor handshake, and keeps score and line totals.
package plate_sequencer_pkg;
  typedef enum logic [2:0] {
    eNop, eMoveLeft, eMoveRight, eMoveDown, eRotate, eCommit, eCheck, eNew
  } opcode_e;
endpackage

module plate_sequencer
  import plate_sequencer_pkg::*;
#(
  parameter int unsigned num_ch_p         = 2,
  parameter int unsigned gravity_period_p = 1000,
  parameter int unsigned lock_delay_p     = 2,
  parameter int unsigned score_width_p    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  opcode_e                  cmd_i [num_ch_p],
  input  logic [num_ch_p-1:0]      cmd_v_i,
  output logic [num_ch_p-1:0]      cmd_ready_o,
  input  logic                     pause_i,
  output opcode_e                  exe_opcode_o,
  output logic                     exe_v_o,
  input  logic                     exe_ready_i,
  input  logic                     exe_done_i,
  input  logic [2:0]               exe_line_elim_i,
  input  logic                     exe_cannot_move_down_i,
  input  logic                     exe_lose_i,
  output logic [score_width_p-1:0] score_o,
  output logic [score_width_p-1:0] lines_o,
  output logic                     lose_o,
  output logic                     busy_o
);

  localparam logic [2:0] StStart = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StLost  = 3'd4;

  localparam int unsigned ChW   = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int unsigned GravW = (gravity_period_p > 1) ? $clog2(gravity_period_p) : 1;
  localparam int unsigned LockW = $clog2(lock_delay_p + 1);
  localparam int unsigned SumW  = score_width_p + 1;
  localparam logic [num_ch_p-1:0] OneCh = 1;

  logic [2:0]               state_q, state_d;
  opcode_e                  cmd_q, cmd_d;
  logic                     auto_v_q, auto_v_d;
  opcode_e                  auto_op_q, auto_op_d;
  logic [GravW-1:0]         grav_cnt_q, grav_cnt_d;
  logic                     grav_pend_q, grav_pend_d;
  logic [LockW-1:0]         lock_q, lock_d;
  logic [ChW-1:0]           last_q, last_d;
  logic [score_width_p-1:0] score_q, score_d;
  logic [score_width_p-1:0] lines_q, lines_d;

  logic           grant_ok, grant_v, grav_clear, grav_tick, lock_fire;
  logic [ChW-1:0] grant_idx;
  int unsigned    idx;
  logic [2:0]     elim;
  logic [3:0]     pts;
  logic [SumW-1:0] score_sum, lines_sum;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = last_q;
    idx       = 0;
    for (int unsigned i = 1; i <= num_ch_p; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= num_ch_p) idx = idx - num_ch_p;
      if (!grant_v && cmd_v_i[ChW'(idx)]) begin
        grant_v   = 1'b1;
        grant_idx = ChW'(idx);
      end
    end
    grant_ok    = (state_q == StIdle) && !pause_i && !auto_v_q && !grav_pend_q;
    cmd_ready_o = (grant_ok && grant_v) ? (OneCh << grant_idx) : '0;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    auto_v_d   = auto_v_q;
    auto_op_d  = auto_op_q;
    last_d     = last_q;
    lock_d     = lock_q;
    score_d    = score_q;
    lines_d    = lines_q;
    grav_clear = 1'b0;
    lock_fire  = 1'b0;
    elim       = (exe_line_elim_i > 3'd4) ? 3'd4 : exe_line_elim_i;
    pts        = 4'd0;
    score_sum  = '0;
    lines_sum  = '0;

    unique case (state_q)
      StStart: begin
        cmd_d   = eNew;
        state_d = StIssue;
      end
      StIdle: begin
        if (auto_v_q) begin
          cmd_d     = auto_op_q;
          auto_v_d  = (auto_op_q == eCheck);
          auto_op_d = eNew;
          state_d   = StIssue;
        end else if (grav_pend_q && !pause_i) begin
          cmd_d      = eMoveDown;
          grav_clear = 1'b1;
          state_d    = StIssue;
        end else if (grant_ok && grant_v) begin
          last_d = grant_idx;
          case (cmd_i[grant_idx])
            eMoveLeft, eMoveRight, eMoveDown, eRotate: begin
              cmd_d   = cmd_i[grant_idx];
              state_d = StIssue;
            end
            eCommit: begin
              cmd_d     = eCommit;
              auto_v_d  = 1'b1;
              auto_op_d = eCheck;
              state_d   = StIssue;
            end
            default: ;
          endcase
        end
      end
      StIssue: begin
        if (exe_ready_i) state_d = StWait;
      end
      StWait: begin
        if (exe_done_i) begin
          if (cmd_q == eMoveDown) begin
            if (!exe_cannot_move_down_i) begin
              lock_d = '0;
            end else if (32'(lock_q) + 1 >= lock_delay_p) begin
              lock_d    = '0;
              lock_fire = 1'b1;
            end else begin
              lock_d = lock_q + LockW'(1);
            end
          end else if (cmd_q == eNew) begin
            lock_d = '0;
          end

          if (cmd_q == eCheck) begin
            unique case (elim)
              3'd0:    pts = 4'd0;
              3'd1:    pts = 4'd1;
              3'd2:    pts = 4'd3;
              3'd3:    pts = 4'd5;
              default: pts = 4'd8;
            endcase
            score_sum = SumW'(score_q) + SumW'(pts);
            lines_sum = SumW'(lines_q) + SumW'(elim);
            score_d   = score_sum[SumW-1] ? '1 : score_sum[score_width_p-1:0];
            lines_d   = lines_sum[SumW-1] ? '1 : lines_sum[score_width_p-1:0];
          end

          if (exe_lose_i) begin
            state_d = StLost;
          end else if (lock_fire) begin
            cmd_d     = eCommit;
            auto_v_d  = 1'b1;
            auto_op_d = eCheck;
            state_d   = StIssue;
          end else if (auto_v_q) begin
            cmd_d     = auto_op_q;
            auto_v_d  = (auto_op_q == eCheck);
            auto_op_d = eNew;
            state_d   = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLost: ;
      default: state_d = StStart;
    endcase
  end

  // A tick arriving in the same cycle its predecessor is issued stays pending.
  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_tick  = 1'b0;
    if (!pause_i && state_q != StLost) begin
      if (grav_cnt_q == GravW'(gravity_period_p - 1)) begin
        grav_cnt_d = '0;
        grav_tick  = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GravW'(1);
      end
    end
    grav_pend_d = grav_tick ? 1'b1 : (grav_clear ? 1'b0 : grav_pend_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StStart;
      cmd_q       <= eNop;
      auto_v_q    <= 1'b0;
      auto_op_q   <= eNop;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      lock_q      <= '0;
      last_q      <= ChW'(num_ch_p - 1);
      score_q     <= '0;
      lines_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      auto_v_q    <= auto_v_d;
      auto_op_q   <= auto_op_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      lock_q      <= lock_d;
      last_q      <= last_d;
      score_q     <= score_d;
      lines_q     <= lines_d;
    end
  end

  assign exe_v_o      = (state_q == StIssue);
  assign exe_opcode_o = cmd_q;
  assign lose_o       = (state_q == StLost);
  assign busy_o       = (state_q != StIdle);
  assign score_o      = score_q;
  assign lines_o      = lines_q;

endmodule
